// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : shared op encodings, FSM states and helpers for muldiv_seq
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int ITER = 32;

  // Magnitude of a 32-bit operand; only negated when the op is signed.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step : one combinational iteration of shift-add multiply or
//               restoring divide (divide path only with MULDIV_DIV_EN)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [63:0] mul_next;

  // acc = {partial product, remaining multiplier bits}; consumes LSB first.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, opnd};
    mul_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        ge;
  logic [63:0] div_next;

  // acc = {remainder, dividend/quotient}; the shifted remainder fits in 33 bits.
  always_comb begin
    rem_sh   = acc[63:31];
    ge       = rem_sh >= {1'b0, opnd};
    diff     = rem_sh[31:0] - opnd;
    div_next = ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    acc_next = is_div ? div_next : mul_next;
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    acc_next = mul_next;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : background 34-cycle mult/div sequencer owning HI/LO, with
//              pipeline stall; divide support under MULDIV_DIV_EN
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_lo;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [63:0] acc_next;
  logic        is_div;
  logic        go;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod;

  assign sgn   = ~op[0];
  assign mag_a = mag(a, sgn);
  assign mag_b = mag(b, sgn);
  assign prod  = neg_lo ? (~acc + 64'd1) : acc;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);
  assign hi    = hi_r;
  assign lo    = lo_r;

`ifdef MULDIV_DIV_EN
  logic div_r;
  logic neg_hi;
  logic b_zero;

  assign go     = 1'b1;
  assign is_div = div_r;
  assign div0   = (state == DONE) & div_r & b_zero;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_r  <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      div_r  <= op[1];
      neg_hi <= sgn & a[31];
      b_zero <= (b == 32'd0);
    end
  end
`else
  // div/divu is swallowed at launch, so the engine only ever multiplies.
  assign go     = ~op[1];
  assign is_div = 1'b0;
  assign div0   = 1'b0;
`endif

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      neg_lo <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (go) begin
              state  <= RUN;
              cnt    <= 5'd0;
              neg_lo <= sgn & (a[31] ^ b[31]);
              if (op[1]) begin
                opnd <= mag_b;
                acc  <= {32'd0, mag_a};
              end else begin
                opnd <= mag_a;
                acc  <= {32'd0, mag_b};
              end
            end
          end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
`ifdef MULDIV_DIV_EN
          if (div_r) begin
            if (!b_zero) begin
              lo_r <= neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
              hi_r <= neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
            end
          end else begin
            hi_r <= prod[63:32];
            lo_r <= prod[31:0];
          end
`else
          hi_r <= prod[63:32];
          lo_r <= prod[31:0];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : directed + random checks of muldiv_seq against an
//                 arithmetic model of HI/LO (divide expectations follow MULDIV_DIV_EN)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_rd;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_seq dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hilo_rd (hilo_rd),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .stall   (stall),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, from plain arithmetic on current HI/LO.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output int eb, output int ed);
    logic [63:0] p;
    longint      q;
    longint      r;
    eh = m_hi; el = m_lo; eb = 33; ed = 0;
    case (o)
      2'b00: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, x} * {32'd0, y};
        eh = p[63:32]; el = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == 32'd0) begin
          ed = 1;
        end else if (o == 2'b10) begin
          q  = longint'($signed(x)) / longint'($signed(y));
          r  = longint'($signed(x)) % longint'($signed(y));
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
`else
        eb = 0;
`endif
      end
    endcase
  endtask

  task automatic wait_busy(output int bn, output int dn, output int di);
    bn = 0; dn = 0; di = 0;
    while (busy && bn < 100) begin
      bn++;
      if (div0) begin dn++; di = bn; end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic lw, input logic [31:0] wd);
    logic [31:0] eh, el;
    int eb, ed, bn, dn, di;
    model(o, x, y, eh, el, eb, ed);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; lo_we = lw; wdata = wd;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    #1;
    wait_busy(bn, dn, di);
    chk({tag, "_busy_cycles"}, 64'(bn), 64'(eb));
    chk({tag, "_div0_pulses"}, 64'(dn), 64'(ed));
    chk({tag, "_div0_cycle"}, 64'(di), (ed != 0) ? 64'd33 : 64'd0);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, eh2, el2;
    int eb, ed, n, bn, dn, di;

    clr = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    clr = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    chk("multu_max_hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_max_lo_const", {32'd0, lo}, 64'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'd0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);

    // mthi / mtlo while idle
    @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", {32'd0, hi}, 64'h11);
    chk("mtlo", {32'd0, lo}, 64'h22);
    m_hi = 32'h11; m_lo = 32'h22;

    // divide by zero, with a concurrent mtlo that start must override
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b1, 32'h5555);

    @(negedge clk); lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk); lo_we = 1'b0;
    chk("mtlo_abcd", {32'd0, lo}, 64'hABCD);
    m_lo = 32'hABCD;

    // mfhi/mflo arriving 5 cycles into an operation
    model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, eb, ed);
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    hilo_rd = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    chk("rd_stall_cycles", 64'(n), 64'd29);
    chk("rd_busy_after", {63'd0, busy}, 64'd0);
    chk("rd_hi", {32'd0, hi}, {32'd0, eh});
    chk("rd_lo", {32'd0, lo}, {32'd0, el});
    hilo_rd = 1'b0;
    m_hi = eh; m_lo = el;

    // back-to-back: second start held and stalled until idle
    model(2'b01, 32'd1000, 32'd3000, eh, el, eb, ed);
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3000;
    @(negedge clk); op = 2'b00; a = 32'hFFFF_FF00; b = 32'd77;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    chk("b2b_stall_cycles", 64'(n), 64'd33);
    chk("b2b_first_hi", {32'd0, hi}, {32'd0, eh});
    chk("b2b_first_lo", {32'd0, lo}, {32'd0, el});
    m_hi = eh; m_lo = el;
    model(2'b00, 32'hFFFF_FF00, 32'd77, eh2, el2, eb, ed);
    @(negedge clk); start = 1'b0;
    #1;
    wait_busy(bn, dn, di);
    chk("b2b_second_busy", 64'(bn), 64'd33);
    chk("b2b_second_hi", {32'd0, hi}, {32'd0, eh2});
    chk("b2b_second_lo", {32'd0, lo}, {32'd0, el2});
    m_hi = eh2; m_lo = el2;

    // asynchronous reset in the middle of an operation
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_hi", {32'd0, hi}, 64'd0);
    chk("clr_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); clr = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    run_op("after_clr", 2'b01, 32'd6, 32'd7, 1'b0, 32'd0);
    chk("after_clr_lo42", {32'd0, lo}, 64'd42);

    for (int i = 0; i < 10; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op("rand", ro, ra, rb, 1'b0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
